// File: rtl/instr_fetch.sv
// Instruction-fetch stage: writable word-addressed instruction memory,
// program counter and instruction register. After a start pulse it walks
// addresses 0..len-1 once, one word per non-stalled cycle, then halts.
// Whenever no real word is being presented, the stage shows an all-zero NOP.
module instr_fetch #(
    parameter int IMEM_DEPTH = 64,
    parameter int AW         = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [31:0]   imem_wdata,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          stall,
    output logic [31:0]   instruction,
    output logic [31:0]   pc,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;

    // The index is one bit wider than an address so that a full-depth
    // program can reach index == IMEM_DEPTH without wrapping back to 0.
    logic [AW:0]     idx_q;
    logic [AW:0]     len_q;
    logic [31:0]     instr_q;
    logic [AW+2:0]   pc_q;
    logic            valid_q;
    logic            more_words;

    logic [31:0]     imem_q [IMEM_DEPTH];

    // True while the fetch index has not yet reached the latched length.
    assign more_words = (idx_q < len_q);

    // Memory write port; memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stall freezes FETCH before the end-of-program test.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = (prog_len == '0) ? S_HALT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (!stall && !more_words) begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded purely from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_FETCH: busy = 1'b1;
            S_HALT:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: length latch, fetch index, and the instruction register,
    // which doubles as the registered read port of the memory (so a
    // same-edge write to the fetched address returns the old word).
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            len_q   <= '0;
            instr_q <= 32'h0000_0000;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        len_q <= prog_len;
                        idx_q <= '0;
                    end
                end
                S_FETCH: begin
                    if (!stall) begin
                        if (more_words) begin
                            instr_q <= imem_q[idx_q[AW-1:0]];
                            pc_q    <= {idx_q, 2'b00};
                            valid_q <= 1'b1;
                            idx_q   <= idx_q + {{AW{1'b0}}, 1'b1};
                        end else begin
                            // Leaving for HALT: present NOP, keep last pc.
                            instr_q <= 32'h0000_0000;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    instr_q <= 32'h0000_0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign pc          = {{(32-AW-3){1'b0}}, pc_q};
    assign valid       = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset values, a stalled program run,
// zero and full-depth lengths, reset mid-run, restart from HALT and a
// same-edge write/fetch collision. One line per transaction.
module tb_instr_fetch;

    localparam int IMEM_DEPTH = 64;
    localparam int AW         = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   prog_len;
    logic          start;
    logic          stall;
    logic [31:0]   instruction;
    logic [31:0]   pc;
    logic          valid;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_mem [IMEM_DEPTH];

    instr_fetch #(.IMEM_DEPTH(IMEM_DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .prog_len    (prog_len),
        .start       (start),
        .stall       (stall),
        .instruction (instruction),
        .pc          (pc),
        .valid       (valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_nop(input string tag);
        check({tag, ".instr"}, instruction, 32'h0);
        check({tag, ".valid"}, {31'b0, valid}, 32'd0);
    endtask

    // Start a run of len words and check every presented word.
    // stall_at/stall_n: stall for stall_n cycles while word stall_at shows.
    // abort_at: assert reset while that word shows, then return.
    // collide_at: write FFFFFFFF to that address on the edge that fetches it.
    task automatic run(input int len, input int stall_at, input int stall_n,
                       input int abort_at, input int collide_at);
        prog_len = (AW+1)'(len);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        $display("run len=%0d: start accepted busy=%0b done=%0b", len, busy, done);
        if (len == 0) begin
            check("len0.done", {31'b0, done}, 32'd1);
            check("len0.busy", {31'b0, busy}, 32'd0);
            check_nop("len0");
            tick();
            check("len0.hold_done", {31'b0, done}, 32'd1);
            check_nop("len0.hold");
            return;
        end
        check("start.busy", {31'b0, busy}, 32'd1);
        check("start.valid", {31'b0, valid}, 32'd0);
        for (int k = 0; k < len; k++) begin
            if (k == collide_at) begin
                imem_we    = 1'b1;
                imem_waddr = AW'(k);
                imem_wdata = 32'hFFFF_FFFF;
            end
            tick();
            imem_we = 1'b0;
            $display("  word %0d: instr=%08h pc=%0d valid=%0b", k, instruction, pc, valid);
            check($sformatf("w%0d.instr", k), instruction, exp_mem[k]);
            check($sformatf("w%0d.pc", k), pc, 32'(k * 4));
            check($sformatf("w%0d.valid", k), {31'b0, valid}, 32'd1);
            if (k == collide_at) begin
                exp_mem[k] = 32'hFFFF_FFFF;
            end
            if (k == stall_at) begin
                stall = 1'b1;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    $display("  stall %0d: instr=%08h pc=%0d", s, instruction, pc);
                    check($sformatf("stall%0d.instr", s), instruction, exp_mem[k]);
                    check($sformatf("stall%0d.pc", s), pc, 32'(k * 4));
                    check($sformatf("stall%0d.valid", s), {31'b0, valid}, 32'd1);
                end
                stall = 1'b0;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                $display("  reset mid-run: busy=%0b done=%0b pc=%0d", busy, done, pc);
                check("abort.busy", {31'b0, busy}, 32'd0);
                check("abort.done", {31'b0, done}, 32'd0);
                check("abort.pc", pc, 32'd0);
                check_nop("abort");
                return;
            end
        end
        tick();
        $display("  halt: done=%0b busy=%0b valid=%0b pc=%0d", done, busy, valid, pc);
        check("halt.done", {31'b0, done}, 32'd1);
        check("halt.busy", {31'b0, busy}, 32'd0);
        check("halt.pc", pc, 32'((len - 1) * 4));
        check_nop("halt");
    endtask

    initial begin
        logic [31:0] prog [9];
        prog = '{32'h08010350, 32'h08020351, 32'h0C220352, 32'h0C420353,
                 32'h04221AB2, 32'h042232A0, 32'h04223AA2, 32'h042242A4,
                 32'h04224AA5};

        rst        = 1'b1;
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;
        prog_len   = '0;
        start      = 1'b0;
        stall      = 1'b0;

        // Reset with random inputs on the other ports.
        for (int c = 0; c < 2; c++) begin
            imem_we    = 1'($urandom_range(0, 1));
            imem_waddr = AW'($urandom);
            imem_wdata = $urandom;
            prog_len   = (AW+1)'($urandom);
            start      = 1'($urandom_range(0, 1));
            stall      = 1'($urandom_range(0, 1));
            tick();
        end
        rst     = 1'b0;
        imem_we = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        $display("reset: instr=%08h pc=%0d valid=%0b busy=%0b done=%0b",
                 instruction, pc, valid, busy, done);
        check("rst.instr", instruction, 32'h0);
        check("rst.pc", pc, 32'd0);
        check("rst.valid", {31'b0, valid}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.done", {31'b0, done}, 32'd0);

        // Load the program plus a distinct filler pattern in the rest.
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            exp_mem[i] = (i < 9) ? prog[i] : (32'hA500_0000 | 32'(i));
            imem_we    = 1'b1;
            imem_waddr = AW'(i);
            imem_wdata = exp_mem[i];
            tick();
        end
        imem_we = 1'b0;
        $display("loaded %0d words", IMEM_DEPTH);
        check("idle.busy", {31'b0, busy}, 32'd0);

        run(9, 2, 3, -1, -1);           // program run with a 3-cycle stall on word 2
        run(3, -1, 0, -1, -1);          // restart from HALT
        run(IMEM_DEPTH, -1, 0, -1, -1); // full depth, last pc 252

        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(0, -1, 0, -1, -1);          // zero length from IDLE
        run(9, -1, 0, 5, -1);           // reset while word 5 shows
        run(9, -1, 0, -1, -1);          // refetch with unchanged memory
        run(9, -1, 0, -1, 4);           // write collision at word 4
        run(9, -1, 0, -1, -1);          // new word 4 visible

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the MIPS CPU. Holds a writable word-addressed instruction memory, a program counter and the instruction register whose output drives the `instruction` input of the control unit. After `start` it fetches addresses 0..`prog_len`-1 in order, one per non-stalled cycle, and then halts. Halted or idle, it presents an all-zero NOP word.

## Interface
- `IMEM_DEPTH`, default 64: instruction memory depth in 32-bit words. Must be a power of two, at least 2.
- `AW`, default 6: address width. Equals log2(`IMEM_DEPTH`).
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_we` input 1: instruction memory write enable.
- `imem_waddr` input AW: word address for the write.
- `imem_wdata` input 32: instruction word to write.
- `prog_len` input AW+1: number of words to fetch. Legal range 0..`IMEM_DEPTH`. Sampled when `start` is accepted.
- `start` input 1: single-cycle pulse that begins a fetch run.
- `stall` input 1: holds the stage. No PC advance and no instruction register update.
- `instruction` output 32: instruction register, feeds the control unit.
- `pc` output 32: byte address of `instruction`, equal to word index × 4.
- `valid` output 1: `instruction` is a real fetched word.
- `busy` output 1: the FSM is in FETCH.
- `done` output 1: the FSM is in HALT.

## Operation
- FSM states: IDLE, FETCH, HALT.
- Reset, or `rst` asserted at any time including mid-run, forces these values on the next edge:
  - state IDLE;
  - internal fetch index 0;
  - `instruction` = 32'h0000_0000;
  - `pc` = 0, `valid` = 0, `busy` = 0, `done` = 0.
- Reset does not clear memory contents.
- IDLE, `start`=1: latch `prog_len` into `len_q`, clear the index, and go to FETCH. If `prog_len`=0, go directly to HALT.
- FETCH, `stall`=0, index < `len_q`:
  - `instruction` ← imem[index];
  - `pc` ← index×4;
  - `valid` ← 1;
  - index ← index+1.
- FETCH, `stall`=0, index = `len_q`: go to HALT.
  - `instruction` ← 0, `valid` ← 0.
  - `pc` holds the last value.
- FETCH, `stall`=1: every register holds, including `valid` and `instruction`. Stall takes priority over the end-of-program check.
- HALT: `done`=1 and outputs stay at NOP.
  - `start`=1 restarts exactly as from IDLE, with a new `prog_len` latched.
- `start` in FETCH is ignored.
- `stall` in IDLE or HALT has no effect.
- Memory write: the write occurs on the edge whenever `imem_we`=1, in any state.
- A same-cycle read of the same address returns the OLD word (read-before-write).
- The index is AW+1 bits wide, so `prog_len`=`IMEM_DEPTH` fetches the last word without wrap-around.
- `pc` upper bits beyond AW+2 are 0.

## Timing
- Accepting `start` at edge N makes the FSM FETCH after N.
- The first instruction (word 0, `pc`=0, `valid`=1) is visible after edge N+1. Latency from start to first valid instruction is 2 edges.
- Without stalls, word k is presented after edge N+1+k. It is held exactly one cycle.
- After the last word, one more edge enters HALT: `done`=1, `valid`=0, `instruction`=0.
- A stall lasting S cycles delays every later word by S cycles. The word being presented stays stable for the whole stall.
- All outputs are registered; none depends combinationally on the inputs.
- `busy` and `done` are decoded from the state register.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with random inputs. Required after release: `instruction`=0, `pc`=0, `valid`=0, `busy`=0, `done`=0.
- **Program run:** load words 0..8 with
  - 0x08010350 (LW)
  - 0x08020351 (LW)
  - 0x0C220352 (SW)
  - 0x0C420353 (SW)
  - 0x04221AB2 (MUL)
  - 0x042232A0 (ADD)
  - 0x04223AA2 (SUB)
  - 0x042242A4 (AND)
  - 0x04224AA5 (OR)

  Then pulse `start` with `prog_len`=9. Required: the 9 words appear on consecutive cycles with `pc` = 0, 4, ..., 32. On the next cycle `done`=1, `valid`=0, `instruction`=0.
- **Stall:** in the same run, hold `stall` for 3 cycles while word 2 (0x0C220352, `pc`=8) is presented. It must stay stable for 4 cycles total, and word 3 follows with no skip or repeat.
- **Boundary lengths:** with `prog_len`=0, `start` leads to `done`=1 one edge later and `valid` never asserts. With `prog_len`=`IMEM_DEPTH`, all 64 words are fetched, the last one with `pc`=252, then HALT.
- **Reset and restart:** assert `rst` while word 5 is presented; IDLE and the NOP word follow on the next edge. Then `start` refetches from word 0 with unchanged memory contents. In HALT, `start` restarts from word 0.
- **Write collision:** during FETCH, write 0xFFFFFFFF to the address being fetched on that same edge. Required: the old word appears now, and the new word appears on the next run.
